// File: rtl/data_mem_pkg.sv
// Shared encodings and helpers for the data memory controller.
package data_mem_pkg;

  localparam logic [1:0] SZ_BYTE  = 2'd0;
  localparam logic [1:0] SZ_HALF  = 2'd1;
  localparam logic [1:0] SZ_WORD  = 2'd2;
  localparam logic [1:0] SZ_DWORD = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // Number of bytes touched by an access of the given size code.
  function automatic logic [31:0] nbytes(input logic [1:0] size);
    return 32'd1 << size;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering for stores, extraction/extension for loads, and alignment check.
module mem_lane_align
  import data_mem_pkg::*;
#(
  parameter int DATA_W = 32,
  localparam int NB    = DATA_W / 8,
  localparam int LSB   = $clog2(NB)
) (
  input  logic [1:0]        i_size,
  input  logic [LSB-1:0]    i_off,
  input  logic              i_unsigned,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [DATA_W-1:0] i_rword,
  output logic [NB-1:0]     o_byte_en,
  output logic [DATA_W-1:0] o_wdata_sh,
  output logic [DATA_W-1:0] o_rdata_ext,
  output logic              o_misalign
);

  logic [31:0]       w_nb;
  logic [31:0]       w_off;
  logic [31:0]       w_bits;
  logic [DATA_W-1:0] w_shifted;
  logic [DATA_W-1:0] w_keep;
  logic [DATA_W-1:0] w_sign_vec;
  logic              w_sign;

  // Lane enables, store shift, load extraction and sign/zero extension.
  always_comb begin
    w_nb       = nbytes(i_size);
    w_off      = 32'(i_off);
    // A dword on a 32-bit array has no legal placement, treat it like a misalignment.
    o_misalign = ((i_size == SZ_DWORD) && (DATA_W == 32)) || ((w_off & (w_nb - 32'd1)) != 32'd0);
    for (int b = 0; b < NB; b++) begin
      o_byte_en[b] = (32'(b) >= w_off) && (32'(b) < w_off + w_nb);
    end
    o_wdata_sh = i_wdata << (8 * w_off);
    w_shifted  = i_rword >> (8 * w_off);
    w_bits     = (8 * w_nb > 32'(DATA_W)) ? 32'(DATA_W) : 8 * w_nb;
    w_keep     = '1;
    if (w_bits < 32'(DATA_W)) begin
      w_keep = ~({DATA_W{1'b1}} << w_bits);
    end
    w_sign_vec  = w_shifted >> (w_bits - 32'd1);
    w_sign      = w_sign_vec[0] & ~i_unsigned;
    // Full-width loads have an all-ones keep mask, so they pass through unextended.
    o_rdata_ext = (w_shifted & w_keep) | (w_sign ? ~w_keep : '0);
  end

endmodule

// File: rtl/data_memory_ctrl.sv
// Single-outstanding data memory with valid/ready request/response and programmable latency.
module data_memory_ctrl
  import data_mem_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int DEPTH   = 32,
  parameter int LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic              i_req_write,
  input  logic [1:0]        i_req_size,
  input  logic              i_req_unsigned,
  input  logic [31:0]       i_req_addr,
  input  logic [DATA_W-1:0] i_req_wdata,
  output logic              o_resp_valid,
  input  logic              i_resp_ready,
  output logic [DATA_W-1:0] o_resp_rdata,
  output logic              o_resp_fault
);

  localparam int NB  = DATA_W / 8;
  localparam int LSB = $clog2(NB);
  localparam int IW  = $clog2(DEPTH);
  localparam logic [1:0] CNT_INIT = (LATENCY > 1) ? 2'(LATENCY - 2) : 2'd0;

  logic [DATA_W-1:0] r_mem [DEPTH];
  state_t            r_state;
  state_t            w_state_nxt;
  logic [1:0]        r_cnt;
  logic [1:0]        w_cnt_nxt;
  logic [DATA_W-1:0] r_rdata;
  logic              r_fault;

  logic [IW-1:0]     w_idx;
  logic [LSB-1:0]    w_off;
  logic              w_accept;
  logic [DATA_W-1:0] w_rword;
  logic [NB-1:0]     w_byte_en;
  logic [DATA_W-1:0] w_wdata_sh;
  logic [DATA_W-1:0] w_rdata_ext;
  logic              w_misalign;
  logic              w_unused_addr;

  assign w_idx         = i_req_addr[LSB +: IW];
  assign w_off         = i_req_addr[LSB-1:0];
  assign w_unused_addr = ^i_req_addr[31:LSB+IW];
  assign w_accept      = i_req_valid && (r_state == ST_IDLE);
  assign w_rword       = r_mem[w_idx];

  mem_lane_align #(.DATA_W(DATA_W)) u_align (
    .i_size      (i_req_size),
    .i_off       (w_off),
    .i_unsigned  (i_req_unsigned),
    .i_wdata     (i_req_wdata),
    .i_rword     (w_rword),
    .o_byte_en   (w_byte_en),
    .o_wdata_sh  (w_wdata_sh),
    .o_rdata_ext (w_rdata_ext),
    .o_misalign  (w_misalign)
  );

  // Commit enabled store lanes on the accepting edge; array is never reset.
  always_ff @(posedge clk) begin
    if (w_accept && i_req_write && !w_misalign) begin
      for (int b = 0; b < NB; b++) begin
        if (w_byte_en[b]) r_mem[w_idx][8*b +: 8] <= w_wdata_sh[8*b +: 8];
      end
    end
  end

  // FSM state and latency counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= 2'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next-state logic: faults skip the wait stage regardless of latency.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          if ((LATENCY == 1) || w_misalign) begin
            w_state_nxt = ST_RESP;
          end else begin
            w_state_nxt = ST_WAIT;
            w_cnt_nxt   = CNT_INIT;
          end
        end
      end
      ST_WAIT: begin
        if (r_cnt == 2'd0) w_state_nxt = ST_RESP;
        else               w_cnt_nxt   = r_cnt - 2'd1;
      end
      ST_RESP: begin
        if (i_resp_ready) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Response data captured at accept and held until the next accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rdata <= '0;
      r_fault <= 1'b0;
    end else if (w_accept) begin
      r_rdata <= (w_misalign || i_req_write) ? '0 : w_rdata_ext;
      r_fault <= w_misalign;
    end
  end

  // Handshake outputs decoded from state.
  always_comb begin
    o_req_ready  = (r_state == ST_IDLE);
    o_resp_valid = (r_state == ST_RESP);
    o_resp_rdata = r_rdata;
    o_resp_fault = r_fault;
  end

endmodule
